srv_icache_sa: RTL and testbench
================================

// Module: srv_icache_sa
// PURPOSE
//  Parametrised set-associative L1 instruction cache for the schoolRISCV fetch path.
//  Sits between the CPU fetch port and the external line-refill interface.
//  Adds configurable sets, ways and line size, and tree-PLRU replacement.
//  Adds a bulk invalidate for fence.i and an explicit miss FSM with a busy indication.
// PARAMETERS
//  CACHE_EN    1  0: every access misses and bypasses; no tag/data/state writes
//  NWAYS       2  ways per set; power of 2, >=2
//  NSETS       4  sets; power of 2, >=1
//  LINE_WORDS  4  32-bit words per line; power of 2, >=2
//  Derived: OFFS_W=clog2(LINE_WORDS), IDX_W=clog2(NSETS), TAG_W=32-OFFS_W-IDX_W
// PORTS
//  clk         in   1              clock
//  rst         in   1              asynchronous reset, active-high
//  imem_req_i  in   1              fetch request; accepted only when busy_o==0
//  imAddr      in   32             word address: [OFFS_W-1:0] offset, next IDX_W index, rest tag
//  imData      out  32             fetched instruction, valid when im_drdy
//  im_drdy     out  1              1-cycle response pulse
//  busy_o      out  1              request in flight or invalidate pending; requests ignored
//  inv_i       in   1              invalidate-all pulse
//  ext_addr_o  out  32             line-aligned word address {tag,index,OFFS_W'0}
//  ext_req_o   out  1              refill request; held until ext_rsp_i
//  ext_rsp_i   in   1              refill data valid, 1 cycle
//  ext_data_i  in   32*LINE_WORDS  refill line; word k at [32k+:32]
// BEHAVIOUR
//  Reset: all outputs 0; all valid bits 0; all PLRU bits 0; FSM in IDLE; pending-inv flag 0.
//  Reset mid-operation aborts any refill immediately; ext_req_o drops asynchronously.
//  FSM states: IDLE, LOOKUP, MISS, FILL.
//   IDLE, imem_req_i=1 -> latch address -> LOOKUP; busy_o=1 from the next cycle.
//   LOOKUP on hit: im_drdy=1 and imData=hit word in this cycle; PLRU updated; next state IDLE.
//    Hit latency is 1 cycle after the request.
//   LOOKUP on miss -> MISS.
//   MISS: ext_req_o=1 and ext_addr_o stable while waiting.
//    On ext_rsp_i=1: write line, tag and valid into the victim way; latch the requested word.
//    Then -> FILL.
//   FILL: im_drdy=1, imData=requested word; next state IDLE.
//  ext_rsp_i outside MISS is ignored.
//  imem_req_i while busy_o=1 is ignored; the requester must hold the request until busy_o=0.
//  imData holds its last value between responses.
//  Victim choice: lowest-index invalid way; if all ways are valid, the tree-PLRU victim.
//  PLRU: NWAYS-1 bits per set. On hit or fill, the bits along the accessed path point away
//   from the accessed way. Misses never update PLRU before the fill.
//  Multiple-way tag match cannot occur; if it does, the lowest way wins (assertion in bench).
//  Invalidate:
//   inv_i in IDLE: all valid and PLRU bits cleared at the next edge.
//   inv_i and imem_req_i together in IDLE: the request is accepted and treated as a forced miss.
//   inv_i in LOOKUP/MISS/FILL: the pending flag is set and busy_o stays 1.
//    The clear is applied on the FILL->IDLE or hit->IDLE transition, after the line write.
//    The in-flight response is still delivered.
//  CACHE_EN=0: LOOKUP always misses; fill delivers data but writes no cache state.
// TESTING
//  (NWAYS=2, NSETS=4, LINE_WORDS=4; set index = addr[3:2]; ext_rsp_i 2 cycles after ext_req_o)
//  1 Cold miss then hit: req 0x10 at cycle N.
//    -> ext_req_o=1 at N+1 with ext_addr_o=0x10.
//    -> rsp {D3,D2,D1,D0} at N+3; im_drdy at N+4 with imData=D0.
//    -> then req 0x11: im_drdy one cycle later, imData=D1, ext_req_o stays 0.
//  2 PLRU: fill 0x00 (way0), fill 0x10 (way1), hit 0x00, req 0x20.
//    -> 0x20 misses and replaces way1.
//    -> then 0x00 hits and 0x10 misses.
//  3 Invalidate in IDLE: after test 1, pulse inv_i, then req 0x10.
//    -> ext_req_o=1 (miss); valid bits were all 0 after the pulse.
//  4 Invalidate during MISS: pulse inv_i while ext_req_o=1.
//    -> response still delivered with correct data.
//    -> busy_o=1 until the clear completes; the same address then misses.
//  5 CACHE_EN=0: three reqs to 0x00.
//    -> each raises ext_req_o; no hit responses occur.
//  6 Reset mid-miss: assert rst while ext_req_o=1.
//    -> ext_req_o, im_drdy and busy_o go 0 immediately.
//    -> a stale ext_rsp_i after reset is ignored; next req 0x00 misses.

Source files
------------

// File: rtl/srv_icache_sa.sv
// srv_icache_sa: set-associative L1 instruction cache for the schoolRISCV fetch path.
// The cache uses tree-PLRU replacement, supports a bulk invalidate for fence.i, and
// handles misses through an explicit miss FSM.
//
// state  | meaning
// IDLE   | waiting for a fetch request; an invalidate is applied here directly
// LOOKUP | tag compare on the latched address; a hit responds in this cycle
// MISS   | refill requested, waiting for ext_rsp_i
// FILL   | deliver the word captured from the refill line
//
// Ports:
//   clk, rst                   clock and asynchronous active-high reset
//   imem_req_i, imAddr         fetch request and word address (accepted only in IDLE)
//   imData, im_drdy            fetched word and its 1-cycle valid pulse
//   busy_o                     high while a request or an invalidate is in flight
//   inv_i                      invalidate-all pulse
//   ext_addr_o, ext_req_o      line-aligned refill request
//   ext_rsp_i, ext_data_i      refill handshake and line data (word k at [32k+:32])
module srv_icache_sa #(
  parameter int CACHE_EN   = 1,
  parameter int NWAYS      = 2,
  parameter int NSETS      = 4,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    imem_req_i,
  input  logic [31:0]             imAddr,
  output logic [31:0]             imData,
  output logic                    im_drdy,
  output logic                    busy_o,
  input  logic                    inv_i,
  output logic [31:0]             ext_addr_o,
  output logic                    ext_req_o,
  input  logic                    ext_rsp_i,
  input  logic [32*LINE_WORDS-1:0] ext_data_i
);
  localparam int OFFS_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(NSETS);
  localparam int TAG_W  = 32 - OFFS_W - IDX_W;
  localparam int WAY_W  = $clog2(NWAYS);
  localparam int SET_W  = (IDX_W > 0) ? IDX_W : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FILL} state_t;
  state_t state_q, state_d;

  logic [31:0]             addr_q;
  logic                    inv_pend_q;
  logic [NWAYS-1:0]        valid_q [NSETS];
  logic [NWAYS-2:0]        plru_q  [NSETS];
  logic [TAG_W-1:0]        tag_q   [NSETS][NWAYS];
  logic [32*LINE_WORDS-1:0] line_q [NSETS][NWAYS];
  logic [31:0]             fill_word_q, hold_q;

  logic [SET_W-1:0]  set_idx;
  logic [TAG_W-1:0]  tag;
  logic [OFFS_W-1:0] offs;
  logic [NWAYS-1:0]  match;
  logic              hit, any_inv, refill, going_idle, clear_now;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_way, victim, acc_way, node;
  logic [NWAYS-2:0]  plru_cur, plru_upd;
  logic [31:0]       hit_word, resp_word;

  assign offs     = addr_q[OFFS_W-1:0];
  assign tag      = addr_q[31 -: TAG_W];
  assign set_idx  = SET_W'((addr_q >> OFFS_W) & 32'(NSETS - 1));
  assign plru_cur = plru_q[set_idx];

  always_comb begin
    match   = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < NWAYS; w++)
      match[w] = (CACHE_EN != 0) && valid_q[set_idx][w] && (tag_q[set_idx][w] == tag);
    // Descending scan so the lowest matching / invalid way is the one left standing.
    for (int w = NWAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way = WAY_W'(w);
      if (!valid_q[set_idx][w]) begin
        inv_way = WAY_W'(w);
        any_inv = 1'b1;
      end
    end
  end
  assign hit      = |match;
  assign hit_word = line_q[set_idx][hit_way][{offs, 5'b0} +: 32];

  // Tree walk: a node bit of 0 points the victim search to the left subtree.
  always_comb begin
    plru_way = '0;
    node     = '0;
    for (int l = 0; l < WAY_W; l++) begin
      plru_way[WAY_W-1-l] = plru_cur[node];
      node = WAY_W'(2 * int'(node) + 1 + int'(plru_cur[node]));
    end
  end
  assign victim  = any_inv ? inv_way : plru_way;
  assign acc_way = (state_q == LOOKUP) ? hit_way : victim;

  // Every node on the accessed path is flipped to point away from acc_way.
  logic [WAY_W-1:0] unode;
  always_comb begin
    plru_upd = plru_cur;
    unode    = '0;
    for (int l = 0; l < WAY_W; l++) begin
      plru_upd[unode] = ~acc_way[WAY_W-1-l];
      unode = WAY_W'(2 * int'(unode) + 1 + int'(acc_way[WAY_W-1-l]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    im_drdy   = 1'b0;
    ext_req_o = 1'b0;
    resp_word = fill_word_q;
    case (state_q)
      IDLE:   if (imem_req_i) state_d = LOOKUP;
      LOOKUP: begin
        if (hit) begin
          im_drdy   = 1'b1;
          resp_word = hit_word;
          state_d   = IDLE;
        end else begin
          // Raised already in the lookup cycle so the refill starts one cycle after the request.
          ext_req_o = 1'b1;
          state_d   = MISS;
        end
      end
      MISS: begin
        ext_req_o = 1'b1;
        if (ext_rsp_i) state_d = FILL;
      end
      FILL: begin
        im_drdy = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o     = (state_q != IDLE) || inv_pend_q;
  assign imData     = im_drdy ? resp_word : hold_q;
  assign ext_addr_o = {addr_q[31:OFFS_W], OFFS_W'(0)};

  assign refill     = (state_q == MISS) && ext_rsp_i;
  assign going_idle = (state_q != IDLE) && (state_d == IDLE);
  assign clear_now  = ((state_q == IDLE) && inv_i) || (going_idle && (inv_pend_q || inv_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      inv_pend_q  <= 1'b0;
      fill_word_q <= '0;
      hold_q      <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if ((state_q == IDLE) && imem_req_i) addr_q <= imAddr;
      if (im_drdy) hold_q <= resp_word;
      if (refill) fill_word_q <= ext_data_i[{offs, 5'b0} +: 32];
      if ((CACHE_EN != 0) && refill) begin
        valid_q[set_idx][victim] <= 1'b1;
        plru_q[set_idx]          <= plru_upd;
      end
      if ((state_q == LOOKUP) && hit) plru_q[set_idx] <= plru_upd;
      if (going_idle)                          inv_pend_q <= 1'b0;
      else if ((state_q != IDLE) && inv_i)     inv_pend_q <= 1'b1;
      // Placed last so a pending clear overrides the line write / PLRU update of the same edge.
      if (clear_now) begin
        for (int s = 0; s < NSETS; s++) begin
          valid_q[s] <= '0;
          plru_q[s]  <= '0;
        end
      end
    end
  end

  // Line and tag storage need no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if ((CACHE_EN != 0) && refill) begin
      line_q[set_idx][victim] <= ext_data_i;
      tag_q[set_idx][victim]  <= tag;
    end
  end
endmodule

// File: tb/tb_srv_icache_sa.sv
module tb_srv_icache_sa;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         imem_req = 1'b0, inv = 1'b0;
  logic [31:0]  im_addr = '0;
  logic [31:0]  im_data, ext_addr;
  logic         im_drdy, busy, ext_req, ext_rsp;
  logic [127:0] ext_data;

  logic         nc_req = 1'b0, nc_rsp = 1'b0, nc_inv = 1'b0;
  logic [31:0]  nc_addr = '0;
  logic [31:0]  nc_data, nc_ext_addr;
  logic         nc_drdy, nc_busy, nc_ext_req;
  logic [127:0] nc_ext_data;

  logic auto_en = 1'b1, auto_rsp = 1'b0, man_rsp = 1'b0;
  int   rsp_cnt = 0, miss_cnt = 0;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'h5A00_0000 + a * 32'h0001_0003;
  endfunction

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[32*k +: 32] = word_of({a[31:2], 2'(k)});
    return l;
  endfunction

  assign ext_rsp     = auto_rsp | man_rsp;
  assign ext_data    = line_of(ext_addr);
  assign nc_ext_data = line_of(nc_ext_addr);

  srv_icache_sa dut (
    .clk(clk), .rst(rst), .imem_req_i(imem_req), .imAddr(im_addr), .imData(im_data),
    .im_drdy(im_drdy), .busy_o(busy), .inv_i(inv), .ext_addr_o(ext_addr),
    .ext_req_o(ext_req), .ext_rsp_i(ext_rsp), .ext_data_i(ext_data));

  srv_icache_sa #(.CACHE_EN(0)) dut_nc (
    .clk(clk), .rst(rst), .imem_req_i(nc_req), .imAddr(nc_addr), .imData(nc_data),
    .im_drdy(nc_drdy), .busy_o(nc_busy), .inv_i(nc_inv), .ext_addr_o(nc_ext_addr),
    .ext_req_o(nc_ext_req), .ext_rsp_i(nc_rsp), .ext_data_i(nc_ext_data));

  // Refill memory: answers 2 cycles after ext_req first appears.
  always @(posedge clk) begin
    #1;
    if (rst || !auto_en) begin
      rsp_cnt  = 0;
      auto_rsp = 1'b0;
    end else if (auto_rsp) begin
      auto_rsp = 1'b0;
      rsp_cnt  = 0;
    end else if (ext_req) begin
      rsp_cnt++;
      if (rsp_cnt == 1) miss_cnt++;
      if (rsp_cnt == 3) auto_rsp = 1'b1;
    end else begin
      rsp_cnt = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && !$onehot0(dut.match)) begin
      errors++;
      $display("FAIL multi_match: got %b want at most one way", dut.match);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request and wait (bounded) for im_drdy; lat = -1 on timeout.
  task automatic req_wait(input logic [31:0] a, output int lat, output logic [31:0] d,
                          output int misses);
    int m0;
    m0 = miss_cnt;
    imem_req = 1'b1;
    im_addr  = a;
    tick();
    imem_req = 1'b0;
    lat = 1;
    while (!im_drdy && lat < 20) begin
      tick();
      lat++;
    end
    if (!im_drdy) lat = -1;
    d      = im_data;
    misses = miss_cnt - m0;
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (im_drdy !== 1'b0) begin errors++; $display("FAIL rst_drdy: got %b want 0", im_drdy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (ext_req !== 1'b0) begin errors++; $display("FAIL rst_ext_req: got %b want 0", ext_req); end
    checks++; if (im_data !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", im_data); end
    checks++; if (ext_addr !== 32'h0) begin errors++; $display("FAIL rst_ext_addr: got %h want 0", ext_addr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_cold_miss_hit();
    int lat, m;
    logic [31:0] d;
    imem_req = 1'b1;
    im_addr  = 32'h10;
    tick();
    imem_req = 1'b0;
    checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL t1_ext_req: got %b want 1", ext_req); end
    checks++; if (ext_addr !== 32'h10) begin errors++; $display("FAIL t1_ext_addr: got %h want 10", ext_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy); end
    tick();
    checks++; if (ext_addr !== 32'h10) begin errors++; $display("FAIL t1_addr_stable: got %h want 10", ext_addr); end
    tick();
    tick();
    checks++; if (im_drdy !== 1'b1) begin errors++; $display("FAIL t1_drdy_n4: got %b want 1", im_drdy); end
    checks++; if (im_data !== word_of(32'h10)) begin errors++; $display("FAIL t1_data: got %h want %h", im_data, word_of(32'h10)); end
    tick();
    checks++; if (im_drdy !== 1'b0) begin errors++; $display("FAIL t1_drdy_pulse: got %b want 0", im_drdy); end
    checks++; if (im_data !== word_of(32'h10)) begin errors++; $display("FAIL t1_hold: got %h want %h", im_data, word_of(32'h10)); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy: got %b want 0", busy); end
    req_wait(32'h11, lat, d, m);
    checks++; if (lat !== 1) begin errors++; $display("FAIL t1_hit_lat: got %0d want 1", lat); end
    checks++; if (d !== word_of(32'h11)) begin errors++; $display("FAIL t1_hit_data: got %h want %h", d, word_of(32'h11)); end
    checks++; if (m !== 0) begin errors++; $display("FAIL t1_hit_noreq: got %0d want 0", m); end
  endtask

  task automatic test_inv_idle();
    int lat, m, n;
    logic [31:0] d;
    inv = 1'b1;
    tick();
    inv = 1'b0;
    req_wait(32'h10, lat, d, m);
    checks++; if (m !== 1) begin errors++; $display("FAIL t3_inv_miss: got %0d want 1", m); end
    checks++; if (d !== word_of(32'h10)) begin errors++; $display("FAIL t3_data: got %h want %h", d, word_of(32'h10)); end
    req_wait(32'h12, lat, d, m);
    checks++; if (m !== 0) begin errors++; $display("FAIL t3_rehit: got %0d misses want 0", m); end
    // invalidate and request together: forced miss on a line that was valid
    inv = 1'b1; imem_req = 1'b1; im_addr = 32'h13;
    tick();
    inv = 1'b0; imem_req = 1'b0;
    checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL t3_forced_miss: got %b want 1", ext_req); end
    n = 0;
    while (!im_drdy && n < 20) begin tick(); n++; end
    checks++; if (im_data !== word_of(32'h13) || im_drdy !== 1'b1) begin errors++; $display("FAIL t3_forced_data: got %h want %h", im_data, word_of(32'h13)); end
    tick();
  endtask

  task automatic test_plru();
    int lat, m;
    logic [31:0] d;
    inv = 1'b1;
    tick();
    inv = 1'b0;
    req_wait(32'h00, lat, d, m);
    checks++; if (m !== 1) begin errors++; $display("FAIL t2_fill00: got %0d misses want 1", m); end
    req_wait(32'h10, lat, d, m);
    checks++; if (m !== 1) begin errors++; $display("FAIL t2_fill10: got %0d misses want 1", m); end
    req_wait(32'h00, lat, d, m);
    checks++; if (m !== 0 || lat !== 1) begin errors++; $display("FAIL t2_hit00: got misses %0d lat %0d want 0/1", m, lat); end
    req_wait(32'h20, lat, d, m);
    checks++; if (m !== 1 || d !== word_of(32'h20)) begin errors++; $display("FAIL t2_fill20: got misses %0d data %h want 1/%h", m, d, word_of(32'h20)); end
    req_wait(32'h01, lat, d, m);
    checks++; if (m !== 0 || d !== word_of(32'h01)) begin errors++; $display("FAIL t2_keep00: got misses %0d data %h want 0/%h", m, d, word_of(32'h01)); end
    req_wait(32'h10, lat, d, m);
    checks++; if (m !== 1) begin errors++; $display("FAIL t2_evict10: got %0d misses want 1", m); end
    // 0x10 replaced 0x20 (way1), so 0x00 still hits and 0x20 is gone
    req_wait(32'h00, lat, d, m);
    checks++; if (m !== 0) begin errors++; $display("FAIL t2_keep00b: got %0d misses want 0", m); end
    req_wait(32'h20, lat, d, m);
    checks++; if (m !== 1) begin errors++; $display("FAIL t2_evict20: got %0d misses want 1", m); end
  endtask

  task automatic test_inv_miss();
    int lat, m;
    logic [31:0] d;
    imem_req = 1'b1;
    im_addr  = 32'h36;
    tick();
    imem_req = 1'b0;
    checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL t4_ext_req: got %b want 1", ext_req); end
    inv = 1'b1;
    tick();
    inv = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_pend: got %b want 1", busy); end
    tick();
    tick();
    checks++; if (im_drdy !== 1'b1 || im_data !== word_of(32'h36)) begin errors++; $display("FAIL t4_resp: got drdy %b data %h want 1/%h", im_drdy, im_data, word_of(32'h36)); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t4_busy_fill: got %b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_busy_clear: got %b want 0", busy); end
    req_wait(32'h36, lat, d, m);
    checks++; if (m !== 1) begin errors++; $display("FAIL t4_remiss: got %0d misses want 1", m); end
    req_wait(32'h00, lat, d, m);
    checks++; if (m !== 1) begin errors++; $display("FAIL t4_global_clear: got %0d misses want 1", m); end
  endtask

  task automatic test_cache_disabled();
    for (int i = 0; i < 3; i++) begin
      nc_req  = 1'b1;
      nc_addr = 32'h00;
      tick();
      nc_req = 1'b0;
      checks++; if (nc_ext_req !== 1'b1) begin errors++; $display("FAIL t5_ext_req%0d: got %b want 1", i, nc_ext_req); end
      checks++; if (nc_drdy !== 1'b0) begin errors++; $display("FAIL t5_nohit%0d: got %b want 0", i, nc_drdy); end
      tick();
      nc_rsp = 1'b1;
      tick();
      nc_rsp = 1'b0;
      checks++; if (nc_drdy !== 1'b1 || nc_data !== word_of(32'h0)) begin errors++; $display("FAIL t5_fill%0d: got drdy %b data %h want 1/%h", i, nc_drdy, nc_data, word_of(32'h0)); end
      tick();
      checks++; if (nc_busy !== 1'b0) begin errors++; $display("FAIL t5_idle%0d: got %b want 0", i, nc_busy); end
    end
  endtask

  task automatic test_reset_mid_miss();
    int lat, m;
    logic [31:0] d;
    req_wait(32'h00, lat, d, m);
    auto_en  = 1'b0;
    imem_req = 1'b1;
    im_addr  = 32'h40;
    tick();
    imem_req = 1'b0;
    checks++; if (ext_req !== 1'b1) begin errors++; $display("FAIL t6_ext_req: got %b want 1", ext_req); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (ext_req !== 1'b0 || im_drdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_async: got req %b drdy %b busy %b want 0/0/0", ext_req, im_drdy, busy); end
    tick();
    rst = 1'b0;
    man_rsp = 1'b1;
    tick();
    man_rsp = 1'b0;
    checks++; if (ext_req !== 1'b0 || im_drdy !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_stale: got req %b drdy %b busy %b want 0/0/0", ext_req, im_drdy, busy); end
    auto_en = 1'b1;
    req_wait(32'h00, lat, d, m);
    checks++; if (m !== 1 || lat !== 4) begin errors++; $display("FAIL t6_remiss: got misses %0d lat %0d want 1/4", m, lat); end
    checks++; if (d !== word_of(32'h0)) begin errors++; $display("FAIL t6_data: got %h want %h", d, word_of(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_cold_miss_hit();
    test_inv_idle();
    test_plru();
    test_inv_miss();
    test_cache_disabled();
    test_reset_mid_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
